// File: rtl/ld_cell_sampler.sv
// Round-robin A2D sequencer: left load cell, right load cell, then battery via a 16-bit SPI master.
// A conversion is a channel command transaction followed by a read transaction; each round is started by the timer tick.
module ld_cell_sampler #(
  parameter bit fast_sim = 1'b0,
  parameter int PERIOD_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        round_done
);

  localparam int TICK_W = fast_sim ? 10 : PERIOD_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_CMD = 2'd1,
    S_GAP      = 2'd2,
    S_WAIT_RD  = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_idx;
  logic [PERIOD_W-1:0] r_tmr;
  logic                r_wrt;
  logic [15:0]         r_cmd;
  logic [11:0]         r_lft;
  logic [11:0]         r_rght;
  logic [11:0]         r_batt;
  logic                r_round_done;
  logic                w_tick;

  // Channel command word: {2'b00, chnl, 11'h000}; idx 0/1/2 map to chnl 0/4/5.
  function automatic logic [15:0] chan_cmd(input logic [1:0] idx);
    logic [2:0] chnl;
    case (idx)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd4;
      default: chnl = 3'd5;
    endcase
    return {2'b00, chnl, 11'h000};
  endfunction

  // Free-running; the FSM only ever samples it, so the round period is independent of SPI latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tmr <= '0;
    else        r_tmr <= r_tmr + 1'b1;
  end

  assign w_tick = &r_tmr[TICK_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_wrt        <= 1'b0;
      r_cmd        <= 16'h0000;
      r_lft        <= 12'h000;
      r_rght       <= 12'h000;
      r_batt       <= 12'h000;
      r_round_done <= 1'b0;
    end else begin
      r_wrt        <= 1'b0;
      r_round_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_wrt   <= 1'b1;
            r_cmd   <= chan_cmd(r_idx);
            r_state <= S_WAIT_CMD;
          end
        end
        S_WAIT_CMD: begin
          if (done) r_state <= S_GAP;
        end
        S_GAP: begin
          r_wrt   <= 1'b1;
          r_cmd   <= 16'h0000;
          r_state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (done) begin
            case (r_idx)
              2'd0:    r_lft  <= rd_data[11:0];
              2'd1:    r_rght <= rd_data[11:0];
              default: r_batt <= rd_data[11:0];
            endcase
            // Next conversion follows immediately; only the round start waits for the timer.
            if (r_idx < 2'd2) begin
              r_idx   <= r_idx + 2'd1;
              r_wrt   <= 1'b1;
              r_cmd   <= chan_cmd(r_idx + 2'd1);
              r_state <= S_WAIT_CMD;
            end else begin
              r_idx        <= 2'd0;
              r_round_done <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wrt   <= 1'b0;
        end
      endcase
    end
  end

  assign wrt        = r_wrt;
  assign cmd        = r_cmd;
  assign lft_ld     = r_lft;
  assign rght_ld    = r_rght;
  assign batt       = r_batt;
  assign round_done = r_round_done;

endmodule
